// File: rtl/constants_pkg.sv
// Shared line/address widths and arbiter enums for the cache-to-memory arbiter.
package constants_pkg;

  localparam int unsigned ICLLEN = 128;
  localparam int unsigned ADDR_W = 32;

  typedef enum logic [1:0] {IDLE, BUSY_IC, BUSY_DC} arb_state_t;

  typedef enum logic {REQ_IC, REQ_DC} arb_src_t;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection between the I-cache and D-cache requests.
// MEM_ARB_RR_EN selects round-robin on ties; otherwise the D-cache wins ties.
module arb_pick
  import constants_pkg::*;
(
  input  logic     ic_req,
  input  logic     dc_req,
  input  arb_src_t last_grant,
  output logic     grant_valid,
  output arb_src_t grant_src
);

`ifndef MEM_ARB_RR_EN
  // Fixed priority keeps the grant history only for visibility.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  always_comb begin
    grant_valid = ic_req | dc_req;
    grant_src   = REQ_DC;
    if (ic_req && !dc_req) begin
      grant_src = REQ_IC;
    end else if (ic_req && dc_req) begin
`ifdef MEM_ARB_RR_EN
      grant_src = (last_grant == REQ_IC) ? REQ_DC : REQ_IC;
`else
      grant_src = REQ_DC;
`endif
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serializes whole-line I-cache and D-cache transactions onto the single memory port.
// Tie-break policy comes from arb_pick (MEM_ARB_RR_EN enables round-robin).
module mem_arbiter #(
  parameter int unsigned ICLLEN = constants_pkg::ICLLEN,
  parameter int unsigned ADDR_W = constants_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_rdy,
  output logic [ICLLEN-1:0] ic_data,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [ICLLEN-1:0] dc_wdata,
  output logic              dc_rdy,
  output logic [ICLLEN-1:0] dc_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ICLLEN-1:0] mem_wdata,
  input  logic              mem_rdy,
  input  logic [ICLLEN-1:0] mem_rdata
);
  import constants_pkg::*;

  // Byte-offset bits within a line are always cleared on the memory side.
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(ICLLEN / 8 - 1);

  arb_state_t        state;
  arb_src_t          last_grant;
  logic              grant_valid;
  arb_src_t          grant_src;
  logic [ADDR_W-1:0] sel_addr;

  arb_pick u_pick (
    .ic_req      (ic_req),
    .dc_req      (dc_req),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_src   (grant_src)
  );

  assign sel_addr = (grant_src == REQ_IC) ? ic_addr : dc_addr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= REQ_IC;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            state     <= (grant_src == REQ_IC) ? BUSY_IC : BUSY_DC;
            mem_req   <= 1'b1;
            mem_addr  <= sel_addr & ~OFF_MASK;
            mem_we    <= (grant_src == REQ_DC) && dc_we;
            mem_wdata <= (grant_src == REQ_DC) ? dc_wdata : '0;
          end
        end
        BUSY_IC, BUSY_DC: begin
          // Completion is never aborted, even if the requester has let go.
          if (mem_rdy) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            last_grant <= (state == BUSY_IC) ? REQ_IC : REQ_DC;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign ic_rdy   = (state == BUSY_IC) && mem_rdy;
  assign dc_rdy   = (state == BUSY_DC) && mem_rdy;
  assign ic_data  = ic_rdy ? mem_rdata : '0;
  assign dc_rdata = (dc_rdy && !mem_we) ? mem_rdata : '0;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single-ported main memory line interface between the instruction-cache refill path and the data-cache refill/writeback path. It sits between both caches and `main_memory`. It serializes whole-line transactions, latches the winning request, and drives the memory port. It routes the memory's one-cycle ready pulse and line data back to the granted requester only.

## Interface
Parameters:
- `ICLLEN`, 128: cache line width in bits, shared by both caches and memory.
- `ADDR_W`, 32: byte address width.

Ports:
- `clk`  input  1  single clock, all logic on rising edge.
- `rst`  input  1  synchronous, active-low reset.
- `ic_req`  input  1  I-cache line fetch request, held until `ic_rdy`.
- `ic_addr`  input  ADDR_W  I-cache byte address, stable while `ic_req`.
- `ic_rdy`  output  1  one-cycle pulse: `ic_data` valid.
- `ic_data`  output  ICLLEN  returned line; 0 when `ic_rdy`=0.
- `dc_req`  input  1  D-cache request, held until `dc_rdy`.
- `dc_we`  input  1  1 = line writeback, 0 = line fill.
- `dc_addr`  input  ADDR_W  D-cache byte address.
- `dc_wdata`  input  ICLLEN  writeback line.
- `dc_rdy`  output  1  one-cycle completion pulse.
- `dc_rdata`  output  ICLLEN  fill line; 0 when `dc_rdy`=0 or for writebacks.
- `mem_req`  output  1  to memory `ldp`; held for the whole transaction.
- `mem_we`, `mem_addr`, `mem_wdata`  output  1/ADDR_W/ICLLEN  latched request.
- `mem_rdy`  input  1  memory `ldr` pulse.
- `mem_rdata`  input  ICLLEN  memory `ldData`.

## Operation
- FSM states are `IDLE`, `BUSY_IC`, and `BUSY_DC`.
- **`IDLE`**
  - `mem_req`=0.
  - If any request is high, pick a winner, latch its address, `we` and wdata, and move to the matching `BUSY_*` state.
  - An I-cache grant always latches `we`=0 and wdata=0.
- **`BUSY_*`**
  - `mem_req`=1 and the latched fields drive the memory port.
  - On `mem_rdy`=1: pulse the granted `*_rdy` in the same cycle (combinational pass-through).
  - On that same cycle, pass `mem_rdata` through to `ic_data`/`dc_rdata` (zeroed for writebacks), update `last_grant`, and return to `IDLE`.
- `mem_rdy` in `IDLE` is ignored. The ungranted requester's outputs stay 0.
- **Address:** `mem_addr` = latched address with the low log2(ICLLEN/8) bits (4 at 128) forced to 0.
- **Requests dropped mid-transaction** are a protocol violation. The arbiter still completes the memory transaction and pulses `*_rdy`; it never aborts.
- **Tie-break:** see Configuration. A single active requester always wins.

## Timing
- **Reset** (`rst`=0 at an edge) puts the arbiter in this state:
  - state=`IDLE`, `last_grant`=IC, `mem_req`=0.
  - `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - `ic_rdy`=`dc_rdy`=0, data outputs 0.
- Reset mid-transaction drops it silently, with no `*_rdy` pulse. Requesters are reset together with the arbiter.
- **Latency:** request sampled in cycle 0 → `mem_req` high from cycle 1. With the current memory (responds one cycle after seeing `ldp`), `*_rdy` arrives in cycle 2. In general, latency is 1 + memory latency.
- The cycle after `*_rdy` is always `IDLE` with `mem_req`=0. This is the earliest next grant decision, so back-to-back transactions are spaced 3 cycles apart.
- Requesters must drop `*_req` in the cycle after `*_rdy`. A request still high in that `IDLE` cycle is treated as a new request.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin on simultaneous requests. The requester not equal to `last_grant` wins.
- `MEM_ARB_RR_EN` undefined: fixed priority, D-cache always wins ties. `last_grant` is still maintained but unused. I-cache starvation is accepted.

## Structure
- `constants_pkg` holds:
  - `ICLLEN` and `ADDR_W`.
  - `typedef enum {IDLE, BUSY_IC, BUSY_DC} arb_state_t`.
  - `typedef enum logic {REQ_IC, REQ_DC} arb_src_t`.
- Sub-module `arb_pick` is combinational.
  - Inputs: `ic_req`, `dc_req`, `last_grant`. Outputs: `grant_valid`, `grant_src`.
  - The `MEM_ARB_RR_EN` choice lives there.
- FSM, latches and return muxing live in `mem_arbiter`.

## Test plan
- **I-fetch alone:** reset, then `ic_req`=1, `ic_addr`=0x104 → `mem_req` from cycle 1, `mem_addr`=0x100, `mem_we`=0, `ic_rdy` pulse in cycle 2 with `ic_data`=0xfe1088e3_0040a103_0010a223_40010093, `dc_rdy`=0 throughout.
- **D writeback:** `dc_req`=1, `dc_we`=1, `dc_addr`=0x2000, `dc_wdata`=0xA5…A5 → `mem_we`=1, `mem_wdata`=0xA5…A5, `dc_rdy` pulse, `dc_rdata`=0.
- **Simultaneous persistent requests with RR:** both held high → grant order DC, IC, DC, IC. Without the macro → DC, DC, DC.
- **Spacing:** `ic_req` released after `ic_rdy` while `dc_req` is pending → `mem_req` low for exactly one cycle between the two transactions.
- **Reset mid-transaction:** `rst`=0 during `BUSY_DC` → next cycle `IDLE`, `mem_req`=0, no `dc_rdy` pulse, then a tie grants DC.
- **Stray `mem_rdy`:** `mem_rdy` asserted while in `IDLE` → no `*_rdy` pulse and no state change.
